// File: rtl/role_trace_ring_writer.sv
// Trace ring writer: buffers AXI-Stream trace beats and drains them as AXI4 INCR
// bursts, one burst per 1 KiB ring slot, into a host-visible ring buffer.
module role_trace_ring_writer #(
    parameter int unsigned ADDR_W     = 36,
    parameter int unsigned DATA_W     = 512,
    parameter int unsigned BURST_LEN  = 16,
    parameter int unsigned FIFO_DEPTH = 32
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                s_axis_trace_tvalid,
    output logic                s_axis_trace_tready,
    input  logic [DATA_W-1:0]   s_axis_trace_tdata,
    input  logic [DATA_W/8-1:0] s_axis_trace_tkeep,
    input  logic                s_axis_trace_tlast,
    input  logic                cfg_enable,
    input  logic [ADDR_W-1:0]   cfg_base,
    input  logic [15:0]         cfg_slots,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic [7:0]          m_axi_awlen,
    output logic [2:0]          m_axi_awsize,
    output logic [1:0]          m_axi_awburst,
    output logic [3:0]          m_axi_awcache,
    output logic                m_axi_awlock,
    output logic [2:0]          m_axi_awprot,
    output logic [3:0]          m_axi_awqos,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    output logic                m_axi_wlast,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    input  logic [1:0]          m_axi_bresp,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,
    output logic [15:0]         stat_slot_idx,
    output logic [31:0]         stat_wrap_cnt,
    output logic                stat_bresp_err,
    output logic                stat_busy
);

    localparam int unsigned KEEP_W     = DATA_W / 8;
    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W      = PTR_W + 1;
    localparam int unsigned ENTRY_W    = DATA_W + KEEP_W + 1;
    localparam int unsigned BLEN_W     = $clog2(BURST_LEN) + 1;
    localparam int unsigned SLOT_SHIFT = $clog2(BURST_LEN * KEEP_W);

    typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;

    state_t              state, state_nxt;
    logic [ENTRY_W-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0]    count, count_nxt, last_cnt, last_cnt_nxt;
    logic                tready_q, en_q, bresp_err;
    logic [ADDR_W-1:0]   base_q, aw_addr_q;
    logic [15:0]         slots_q, slot_idx;
    logic [31:0]         wrap_cnt;
    logic [BLEN_W-1:0]   blen_q, blen_c, beat_cnt;
    logic [ENTRY_W-1:0]  rd_entry;
    logic                push, pop, start, wlast_c, slot_wrap;

    assign rd_entry  = mem[rd_ptr];
    assign push      = s_axis_trace_tvalid && tready_q;
    assign pop       = (state == S_W) && (count != '0) && m_axi_wready;
    assign count_nxt = count + CNT_W'(push) - CNT_W'(pop);
    assign last_cnt_nxt = last_cnt + CNT_W'(push && s_axis_trace_tlast)
                        - CNT_W'(pop && rd_entry[ENTRY_W-1]);
    // A full burst is ready, or a record end is buffered and must be flushed.
    assign start     = en_q && cfg_enable &&
                       ((count >= CNT_W'(BURST_LEN)) || ((last_cnt != '0) && (count != '0)));
    assign blen_c    = (count >= CNT_W'(BURST_LEN)) ? BLEN_W'(BURST_LEN) : BLEN_W'(count);
    assign wlast_c   = (beat_cnt == BLEN_W'(blen_q - BLEN_W'(1)));
    assign slot_wrap = (17'(slot_idx) + 17'd1) >= 17'(slots_q);

    // Next-state and channel handshake decode.
    always_comb begin
        state_nxt      = state;
        m_axi_awvalid  = 1'b0;
        m_axi_wvalid   = 1'b0;
        m_axi_wlast    = 1'b0;
        m_axi_bready   = 1'b0;
        unique case (state)
            S_IDLE: if (start) state_nxt = S_AW;
            S_AW: begin
                m_axi_awvalid = 1'b1;
                if (m_axi_awready) state_nxt = S_W;
            end
            S_W: begin
                m_axi_wvalid = (count != '0);
                m_axi_wlast  = wlast_c;
                if (pop && wlast_c) state_nxt = S_B;
            end
            S_B: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state     <= S_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            last_cnt  <= '0;
            tready_q  <= 1'b0;
            en_q      <= 1'b0;
            base_q    <= '0;
            slots_q   <= 16'd1;
            slot_idx  <= '0;
            wrap_cnt  <= '0;
            bresp_err <= 1'b0;
            aw_addr_q <= '0;
            blen_q    <= '0;
            beat_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            last_cnt <= last_cnt_nxt;
            tready_q <= (count_nxt != CNT_W'(FIFO_DEPTH));
            en_q     <= cfg_enable;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if ((state == S_IDLE) && start) begin
                aw_addr_q <= base_q + (ADDR_W'(slot_idx) << SLOT_SHIFT);
                blen_q    <= blen_c;
                beat_cnt  <= '0;
            end else if (pop) begin
                beat_cnt <= beat_cnt + BLEN_W'(1);
            end
            if ((state == S_B) && m_axi_bvalid) begin
                if (m_axi_bresp != 2'b00) bresp_err <= 1'b1;
                if (slot_wrap) begin
                    slot_idx <= '0;
                    if (wrap_cnt != 32'hFFFF_FFFF) wrap_cnt <= wrap_cnt + 32'd1;
                end else begin
                    slot_idx <= slot_idx + 16'd1;
                end
            end
            // Enable rising edge restarts the ring at slot 0 with fresh config.
            if (cfg_enable && !en_q) begin
                base_q   <= cfg_base;
                slots_q  <= cfg_slots;
                slot_idx <= '0;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (push) mem[wr_ptr] <= {s_axis_trace_tlast, s_axis_trace_tkeep, s_axis_trace_tdata};
    end

    assign s_axis_trace_tready = tready_q;
    assign m_axi_awaddr   = aw_addr_q;
    assign m_axi_awlen    = 8'(blen_q) - 8'd1;
    assign m_axi_awsize   = 3'd6;
    assign m_axi_awburst  = 2'b01;
    assign m_axi_awcache  = 4'b0011;
    assign m_axi_awlock   = 1'b0;
    assign m_axi_awprot   = 3'd0;
    assign m_axi_awqos    = 4'd0;
    assign m_axi_wdata    = rd_entry[DATA_W-1:0];
    assign m_axi_wstrb    = rd_entry[DATA_W+KEEP_W-1:DATA_W];
    assign stat_slot_idx  = slot_idx;
    assign stat_wrap_cnt  = wrap_cnt;
    assign stat_bresp_err = bresp_err;
    assign stat_busy      = (state != S_IDLE) || (count != '0);

endmodule
